ahb_sram_ctrl: RTL and testbench

//  AHB-Lite slave that turns bus transfers into cycles on the core's synchronous SRAM port
//  (sram_cen/wen/ben active-low; dout registered one edge after the access).

---
 rtl/ahb_sram_ctrl_pkg.sv | 28 ++
 rtl/ahb_sram_lane_dec.sv | 34 +++
 rtl/ahb_sram_ctrl.sv | 149 ++++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_ctrl_pkg.sv
// ahb_sram_ctrl_pkg
//   Shared types for the AHB-Lite to synchronous SRAM bridge:
//     htrans_e          - AHB-Lite transfer type encoding
//     HSIZE_*           - supported transfer sizes
//     ahb_sram_state_e  - controller FSM states
package ahb_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_ERR1    = 3'd4,
        ST_ERR2    = 3'd5
    } ahb_sram_state_e;

endpackage

// File: rtl/ahb_sram_lane_dec.sv
// ahb_sram_lane_dec
//   Combinational byte-lane decode for one AHB transfer.
//   Ports:
//     i_addr     [1:0]  low byte-address bits
//     i_size     [2:0]  HSIZE
//     o_ben      [3:0]  active-low SRAM byte enables
//     o_misalign        unsupported size or misaligned address
module ahb_sram_lane_dec
    import ahb_sram_ctrl_pkg::*;
(
    input  logic [1:0] i_addr,
    input  logic [2:0] i_size,
    output logic [3:0] o_ben,
    output logic       o_misalign
);

    always_comb begin
        o_ben      = '1;
        o_misalign = 1'b0;
        case (i_size)
            HSIZE_BYTE: o_ben = ~(4'b0001 << i_addr);
            HSIZE_HALF: begin
                o_ben      = ~(4'b0011 << {i_addr[1], 1'b0});
                o_misalign = i_addr[0];
            end
            HSIZE_WORD: begin
                o_ben      = '0;
                o_misalign = |i_addr;
            end
            default:    o_misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl
//   AHB-Lite slave driving a synchronous single-port SRAM (active-low controls,
//   read data valid the cycle after the access edge). Writes are zero-wait,
//   reads take one wait state, illegal transfers get a two-cycle ERROR.
//   Configuration macro: AHB_SRAM_RANGE_ERR_EN - when defined, HADDR >= MEM_BYTES
//   raises ERROR; when undefined the full address is passed and the SRAM aliases.
//   Ports:
//     HCLK, HRESET (async, active-high)
//     HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY  - AHB-Lite slave inputs
//     HREADYOUT, HRESP, HRDATA                            - AHB-Lite slave outputs
//     sram_cen, sram_wen, sram_ben, sram_addr, sram_din   - SRAM controls (active-low)
//     sram_dout                                           - SRAM read data
module ahb_sram_ctrl
    import ahb_sram_ctrl_pkg::*;
#(
    parameter longint unsigned MEM_BYTES = 64'h0000_0000_0400_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        sram_cen,
    output logic        sram_wen,
    output logic [3:0]  sram_ben,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_din,
    input  logic [31:0] sram_dout
);

    // The range check needs at least one full word of memory.
    if (MEM_BYTES < 64'd4) begin : g_mem_bytes_chk
        $error("ahb_sram_ctrl: MEM_BYTES must be at least 4");
    end

    ahb_sram_state_e r_state;
    logic            r_hreadyout;
    logic            r_hresp;
    logic            r_cen;
    logic            r_wen;
    logic [3:0]      r_ben;
    logic [31:0]     r_addr;

    htrans_e         w_htrans;
    logic            w_accept;
    logic [3:0]      w_ben;
    logic            w_misalign;
    logic            w_err;

    assign w_htrans = htrans_e'(HTRANS);
    assign w_accept = HSEL & HREADY &
                      ((w_htrans == HTRANS_NONSEQ) | (w_htrans == HTRANS_SEQ));

    ahb_sram_lane_dec u_lane_dec (
        .i_addr     (HADDR[1:0]),
        .i_size     (HSIZE),
        .o_ben      (w_ben),
        .o_misalign (w_misalign)
    );

`ifdef AHB_SRAM_RANGE_ERR_EN
    assign w_err = w_misalign | ({32'h0, HADDR} >= MEM_BYTES);
`else
    assign w_err = w_misalign;
`endif

    // SRAM controls and bus handshake are registered alongside the next state,
    // so each state's outputs are already valid at the start of its cycle.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_cen       <= 1'b1;
            r_wen       <= 1'b1;
            r_ben       <= '1;
            r_addr      <= '0;
        end else begin
            case (r_state)
                ST_RD_WAIT: begin
                    r_state     <= ST_RD_DATA;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                    r_cen       <= 1'b1;
                    r_wen       <= 1'b1;
                    r_ben       <= '1;
                end
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                // IDLE and every transfer-ending state may take the next transfer.
                default: begin
                    if (w_accept && w_err) begin
                        r_state     <= ST_ERR1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 1'b1;
                        r_cen       <= 1'b1;
                        r_wen       <= 1'b1;
                        r_ben       <= '1;
                    end else if (w_accept && HWRITE) begin
                        r_state     <= ST_WRITE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                        r_cen       <= 1'b0;
                        r_wen       <= 1'b0;
                        r_ben       <= w_ben;
                        r_addr      <= {HADDR[31:2], 2'b00};
                    end else if (w_accept) begin
                        r_state     <= ST_RD_WAIT;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 1'b0;
                        r_cen       <= 1'b0;
                        r_wen       <= 1'b1;
                        r_ben       <= '0;
                        r_addr      <= {HADDR[31:2], 2'b00};
                    end else begin
                        r_state     <= ST_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                        r_cen       <= 1'b1;
                        r_wen       <= 1'b1;
                        r_ben       <= '1;
                    end
                end
            endcase
        end
    end

    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;
    assign sram_cen  = r_cen;
    assign sram_wen  = r_wen;
    assign sram_ben  = r_ben;
    assign sram_addr = r_addr;

    // Write data arrives in the data phase, so it is passed straight through.
    assign sram_din  = (r_state == ST_WRITE)   ? HWDATA    : '0;
    assign HRDATA    = (r_state == ST_RD_DATA) ? sram_dout : '0;

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
module tb_ahb_sram_ctrl;
    import ahb_sram_ctrl_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        sram_cen;
    logic        sram_wen;
    logic [3:0]  sram_ben;
    logic [31:0] sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout = '0;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_sram_ctrl #(.MEM_BYTES(64'h0000_0000_0400_0000)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADYOUT),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_ben  (sram_ben),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    // Behavioural synchronous SRAM: one access per edge, read data next cycle.
    logic [31:0] mem [logic [29:0]];
    logic [31:0] m_word;
    int          wr_count = 0;

    always @(posedge HCLK) begin
        if (!sram_cen) begin
            m_word = mem.exists(sram_addr[31:2]) ? mem[sram_addr[31:2]] : 32'h0;
            if (!sram_wen) begin
                for (int b = 0; b < 4; b++)
                    if (!sram_ben[b]) m_word[b*8 +: 8] = sram_din[b*8 +: 8];
                mem[sram_addr[31:2]] = m_word;
                wr_count++;
            end else begin
                sram_dout <= m_word;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_phase(input logic wr, input logic [2:0] sz, input logic [31:0] a);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HSIZE  = sz;
        HADDR  = a;
    endtask

    task automatic no_xfer();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        no_xfer();
        HSIZE  = 3'd0;
        HADDR  = '0;
        HWDATA = '0;
        tick(); tick();
        @(negedge HCLK);
        checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL rst_hready got %0b exp 1", HREADYOUT); end
        checks++; if (HRESP !== 1'b0) begin errors++; $display("FAIL rst_hresp got %0b exp 0", HRESP); end
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rst_hrdata got %h exp 0", HRDATA); end
        checks++; if ({sram_cen, sram_wen, sram_ben} !== 6'b11_1111) begin errors++; $display("FAIL rst_ctrl got %b exp 111111", {sram_cen, sram_wen, sram_ben}); end
        checks++; if (sram_addr !== 32'h0 || sram_din !== 32'h0) begin errors++; $display("FAIL rst_addr_din got %h/%h exp 0/0", sram_addr, sram_din); end
        tick();
        HRESET = 1'b0;
        tick();
    endtask

    task automatic test_idle_busy();
        HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HSIZE = HSIZE_WORD; HADDR = 32'h100;
        tick();
        HSEL = 1'b1; HTRANS = 2'b00;
        @(negedge HCLK);
        checks++; if ({HREADYOUT, HRESP, sram_cen} !== 3'b101) begin errors++; $display("FAIL busy_okay got %b exp 101", {HREADYOUT, HRESP, sram_cen}); end
        no_xfer();
        tick();
    endtask

    task automatic test_write_read();
        addr_phase(1'b1, HSIZE_WORD, 32'h100);
        tick();
        HWDATA = 32'hDEADBEEF;
        no_xfer();
        @(negedge HCLK);
        checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL wr_hready got %0b exp 1", HREADYOUT); end
        checks++; if ({sram_cen, sram_wen, sram_ben} !== 6'b00_0000) begin errors++; $display("FAIL wr_ctrl got %b exp 000000", {sram_cen, sram_wen, sram_ben}); end
        checks++; if (sram_din !== 32'hDEADBEEF || sram_addr !== 32'h100) begin errors++; $display("FAIL wr_din_addr got %h/%h exp deadbeef/00000100", sram_din, sram_addr); end
        tick();
        addr_phase(1'b0, HSIZE_WORD, 32'h100);
        tick();
        no_xfer();
        @(negedge HCLK);
        checks++; if ({HREADYOUT, sram_cen, sram_wen, sram_ben} !== 7'b0_01_0000) begin errors++; $display("FAIL rd_wait got %b exp 0010000", {HREADYOUT, sram_cen, sram_wen, sram_ben}); end
        tick();
        @(negedge HCLK);
        checks++; if (HREADYOUT !== 1'b1 || HRDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %0b/%h exp 1/deadbeef", HREADYOUT, HRDATA); end
        tick();
    endtask

    task automatic test_byte_lanes();
        addr_phase(1'b1, HSIZE_WORD, 32'h100);
        tick();
        HWDATA = 32'h11223344;
        addr_phase(1'b1, HSIZE_BYTE, 32'h102);
        tick();
        HWDATA = 32'h00AA0000;
        addr_phase(1'b1, HSIZE_HALF, 32'h106);
        @(negedge HCLK);
        checks++; if (sram_ben !== 4'b1011 || sram_addr !== 32'h100 || sram_din !== 32'h00AA0000) begin errors++; $display("FAIL byte_lane got %b/%h/%h exp 1011/00000100/00aa0000", sram_ben, sram_addr, sram_din); end
        tick();
        HWDATA = 32'hBEEF0000;
        no_xfer();
        @(negedge HCLK);
        checks++; if (sram_ben !== 4'b0011 || sram_addr !== 32'h104) begin errors++; $display("FAIL half_lane got %b/%h exp 0011/00000104", sram_ben, sram_addr); end
        tick();
        addr_phase(1'b0, HSIZE_WORD, 32'h100);
        tick();
        no_xfer();
        tick();
        @(negedge HCLK);
        checks++; if (HRDATA !== 32'h11AA3344) begin errors++; $display("FAIL byte_readback got %h exp 11aa3344", HRDATA); end
        addr_phase(1'b0, HSIZE_WORD, 32'h104);
        tick();
        no_xfer();
        tick();
        @(negedge HCLK);
        checks++; if (HRDATA !== 32'hBEEF0000) begin errors++; $display("FAIL half_readback got %h exp beef0000", HRDATA); end
        tick();
    endtask

    task automatic test_back_to_back();
        addr_phase(1'b1, HSIZE_WORD, 32'h200);
        tick();
        HWDATA = 32'h55667788;
        addr_phase(1'b0, HSIZE_WORD, 32'h200);
        @(negedge HCLK);
        checks++; if ({HREADYOUT, sram_cen, sram_wen} !== 3'b100) begin errors++; $display("FAIL b2b_write got %b exp 100", {HREADYOUT, sram_cen, sram_wen}); end
        tick();
        no_xfer();
        @(negedge HCLK);
        checks++; if (HREADYOUT !== 1'b0 || HRDATA !== 32'h0) begin errors++; $display("FAIL b2b_wait got %0b/%h exp 0/0", HREADYOUT, HRDATA); end
        tick();
        @(negedge HCLK);
        checks++; if (HREADYOUT !== 1'b1 || HRDATA !== 32'h55667788) begin errors++; $display("FAIL b2b_read got %0b/%h exp 1/55667788", HREADYOUT, HRDATA); end
        tick();
    endtask

    task automatic test_error();
        int wc;
        wc = wr_count;
        addr_phase(1'b0, HSIZE_WORD, 32'h101);
        tick();
        addr_phase(1'b0, HSIZE_WORD, 32'h100);
        @(negedge HCLK);
        checks++; if ({HREADYOUT, HRESP, sram_cen} !== 3'b011) begin errors++; $display("FAIL err1 got %b exp 011", {HREADYOUT, HRESP, sram_cen}); end
        tick();
        @(negedge HCLK);
        checks++; if ({HREADYOUT, HRESP, sram_cen} !== 3'b111) begin errors++; $display("FAIL err2 got %b exp 111", {HREADYOUT, HRESP, sram_cen}); end
        tick();
        no_xfer();
        @(negedge HCLK);
        checks++; if ({HREADYOUT, HRESP, sram_cen} !== 3'b000) begin errors++; $display("FAIL err_next_wait got %b exp 000", {HREADYOUT, HRESP, sram_cen}); end
        tick();
        @(negedge HCLK);
        checks++; if (HRESP !== 1'b0 || HRDATA !== 32'h11AA3344) begin errors++; $display("FAIL err_next_read got %0b/%h exp 0/11aa3344", HRESP, HRDATA); end
        tick();
        addr_phase(1'b1, 3'd3, 32'h100);
        tick();
        addr_phase(1'b1, HSIZE_HALF, 32'h101);
        @(negedge HCLK);
        checks++; if ({HREADYOUT, HRESP} !== 2'b01) begin errors++; $display("FAIL size_err got %b exp 01", {HREADYOUT, HRESP}); end
        tick(); tick();
        no_xfer();
        @(negedge HCLK);
        checks++; if ({HREADYOUT, HRESP, sram_cen} !== 3'b011) begin errors++; $display("FAIL half_misalign got %b exp 011", {HREADYOUT, HRESP, sram_cen}); end
        tick(); tick();
        checks++; if (wr_count !== wc) begin errors++; $display("FAIL err_no_write got %0d exp %0d", wr_count, wc); end
    endtask

    task automatic test_reset_mid_read();
        int wc;
        wc = wr_count;
        addr_phase(1'b0, HSIZE_WORD, 32'h100);
        tick();
        no_xfer();
        @(negedge HCLK);
        checks++; if (HREADYOUT !== 1'b0) begin errors++; $display("FAIL mid_rd_wait got %0b exp 0", HREADYOUT); end
        HRESET = 1'b1;
        #1;
        checks++; if ({HREADYOUT, HRESP, sram_cen} !== 3'b101) begin errors++; $display("FAIL async_rst got %b exp 101", {HREADYOUT, HRESP, sram_cen}); end
        tick();
        @(negedge HCLK);
        checks++; if (sram_cen !== 1'b1 || HRDATA !== 32'h0 || wr_count !== wc) begin errors++; $display("FAIL rst_held got cen %0b rd %h wr %0d exp 1/0/%0d", sram_cen, HRDATA, wr_count, wc); end
        tick();
        HRESET = 1'b0;
        tick();
    endtask

    task automatic test_addr_wrap();
        addr_phase(1'b0, HSIZE_WORD, 32'h0400_0000);
        tick();
        no_xfer();
        @(negedge HCLK);
`ifdef AHB_SRAM_RANGE_ERR_EN
        checks++; if ({HREADYOUT, HRESP, sram_cen} !== 3'b011) begin errors++; $display("FAIL range_err1 got %b exp 011", {HREADYOUT, HRESP, sram_cen}); end
        tick();
        @(negedge HCLK);
        checks++; if ({HREADYOUT, HRESP, sram_cen} !== 3'b111) begin errors++; $display("FAIL range_err2 got %b exp 111", {HREADYOUT, HRESP, sram_cen}); end
`else
        checks++; if ({HREADYOUT, HRESP, sram_cen} !== 3'b000 || sram_addr !== 32'h0400_0000) begin errors++; $display("FAIL wrap_access got %b/%h exp 000/04000000", {HREADYOUT, HRESP, sram_cen}, sram_addr); end
        tick();
        @(negedge HCLK);
        checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin errors++; $display("FAIL wrap_okay got %b exp 10", {HREADYOUT, HRESP}); end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_busy();
        test_write_read();
        test_byte_lanes();
        test_back_to_back();
        test_error();
        test_reset_mid_read();
        test_addr_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
